// File: rtl/trace_cmd_queue.sv
// Command/address FIFO between the trace source and the cache model. It tracks issued-but-not-done
// operations, holds barrier commands until the pipe drains, and keeps per-command counters.
module trace_cmd_queue #(
  parameter int unsigned CMD_W       = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_CMDS    = 10,
  parameter int unsigned BARRIER_CMD = 9,
  parameter int unsigned MAX_OUT     = 4,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LVL_W      = $clog2(DEPTH) + 1,
  localparam int unsigned OUT_W      = $clog2(MAX_OUT) + 1
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic                      in_valid,
  input  logic [CMD_W-1:0]          in_cmd,
  input  logic [ADDR_W-1:0]         in_addr,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [CMD_W-1:0]          out_cmd,
  output logic [ADDR_W-1:0]         out_addr,
  input  logic                      out_ready,
  input  logic                      cache_done,
  output logic                      full,
  output logic                      empty,
  output logic [LVL_W-1:0]          level,
  output logic [OUT_W-1:0]          outstanding,
  output logic [NUM_CMDS*CNT_W-1:0] cmd_count,
  output logic                      err_illegal,
  output logic                      err_underflow
);

  logic [CMD_W-1:0]  cmd_mem_q  [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q [NUM_CMDS];
  logic [CNT_W-1:0] cnt_d [NUM_CMDS];
  logic             err_ill_q, err_ill_d;
  logic             err_unf_q, err_unf_d;

  logic        push, legal, store, pop;
  logic        slot_free, barrier_ok;
  logic [31:0] in_cmd_ext, head_cmd_ext, out_ext;

  // Status flags depend on registered state only.
  assign full        = (level_q == LVL_W'(DEPTH));
  assign empty       = (level_q == '0);
  assign in_ready    = !full;
  assign level       = level_q;
  assign outstanding = out_q;
  assign err_illegal   = err_ill_q;
  assign err_underflow = err_unf_q;

  assign push       = in_valid && in_ready;
  assign in_cmd_ext = 32'(in_cmd);
  assign legal      = (in_cmd_ext < NUM_CMDS);
  assign store      = push && legal;

  // Show-ahead head, forced to zero while empty.
  assign out_cmd  = empty ? '0 : cmd_mem_q[rd_ptr_q];
  assign out_addr = empty ? '0 : addr_mem_q[rd_ptr_q];

  assign head_cmd_ext = 32'(out_cmd);
  assign out_ext      = 32'(out_q);
  assign slot_free    = (out_ext < MAX_OUT);
  assign barrier_ok   = (head_cmd_ext != BARRIER_CMD) || (out_q == '0);
  assign out_valid    = !empty && slot_free && barrier_ok;
  assign pop          = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({store, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Issue and retire in the same cycle cancel out, even from zero.
  always_comb begin
    out_d     = out_q;
    err_unf_d = err_unf_q;
    if (pop && !cache_done) begin
      out_d = out_q + OUT_W'(1);
    end else if (!pop && cache_done) begin
      if (out_q == '0) begin
        err_unf_d = 1'b1;
      end else begin
        out_d = out_q - OUT_W'(1);
      end
    end
  end

  always_comb begin
    err_ill_d = err_ill_q;
    if (push && !legal) begin
      err_ill_d = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_CMDS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (store && (in_cmd_ext == k) && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cmd_count = '0;
    for (int unsigned k = 0; k < NUM_CMDS; k++) begin
      cmd_count[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      out_q     <= '0;
      err_ill_q <= 1'b0;
      err_unf_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_CMDS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      out_q     <= out_d;
      err_ill_q <= err_ill_d;
      err_unf_q <= err_unf_d;
      for (int unsigned k = 0; k < NUM_CMDS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (store) begin
      cmd_mem_q[wr_ptr_q]  <= in_cmd;
      addr_mem_q[wr_ptr_q] <= in_addr;
    end
  end

endmodule

// File: tb/tb_trace_cmd_queue.sv
// Directed bench for trace_cmd_queue: flow, full/wrap, barrier, MAX_OUT, errors, async reset.
module tb_trace_cmd_queue;

  localparam int unsigned CMD_W    = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned NUM_CMDS = 10;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W    = $clog2(4) + 1;

  logic                      clk;
  logic                      clear_n;
  logic                      in_valid;
  logic [CMD_W-1:0]          in_cmd;
  logic [ADDR_W-1:0]         in_addr;
  logic                      in_ready;
  logic                      out_valid;
  logic [CMD_W-1:0]          out_cmd;
  logic [ADDR_W-1:0]         out_addr;
  logic                      out_ready;
  logic                      cache_done;
  logic                      full;
  logic                      empty;
  logic [LVL_W-1:0]          level;
  logic [OUT_W-1:0]          outstanding;
  logic [NUM_CMDS*CNT_W-1:0] cmd_count;
  logic                      err_illegal;
  logic                      err_underflow;

  int total;
  int bad;

  trace_cmd_queue #(
    .CMD_W(CMD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_CMDS(NUM_CMDS),
    .BARRIER_CMD(9), .MAX_OUT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_cmd(in_cmd), .in_addr(in_addr),
    .in_ready(in_ready), .out_valid(out_valid), .out_cmd(out_cmd), .out_addr(out_addr),
    .out_ready(out_ready), .cache_done(cache_done), .full(full), .empty(empty), .level(level),
    .outstanding(outstanding), .cmd_count(cmd_count), .err_illegal(err_illegal),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_cmd = '0; in_addr = '0; out_ready = 1'b0; cache_done = 1'b0;
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (level !== '0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (outstanding !== '0) begin bad++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    total++; if (cmd_count !== '0) begin bad++; $display("FAIL rst_cmd_count got=%h exp=0", cmd_count); end
    total++; if ({err_illegal, err_underflow} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b%b exp=00", err_illegal, err_underflow); end
  endtask

  task automatic test_basic();
    int n_iss;
    logic prev_iss;
    in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h10; out_ready = 1'b1; cache_done = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_first_valid got=%b exp=1", out_valid); end
    n_iss = 0; prev_iss = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 2) begin
        in_cmd = 4'(c + 1); in_addr = 32'((c + 2) * 16);
      end else begin
        in_valid = 1'b0;
      end
      cache_done = prev_iss;
      prev_iss = out_valid;
      if (out_valid) begin
        total++; if (out_cmd !== 4'(n_iss)) begin bad++; $display("FAIL basic_cmd got=%0d exp=%0d", out_cmd, n_iss); end
        total++; if (out_addr !== 32'((n_iss + 1) * 16)) begin bad++; $display("FAIL basic_addr got=%h exp=%h", out_addr, (n_iss + 1) * 16); end
        n_iss++;
      end
      tick();
    end
    in_valid = 1'b0; cache_done = 1'b0;
    total++; if (n_iss != 3) begin bad++; $display("FAIL basic_issue_count got=%0d exp=3", n_iss); end
    for (int k = 0; k < 3; k++) begin
      total++; if (cmd_count[k*CNT_W +: CNT_W] !== 32'd1) begin bad++; $display("FAIL basic_cnt%0d got=%0d exp=1", k, cmd_count[k*CNT_W +: CNT_W]); end
    end
    total++; if (outstanding !== '0) begin bad++; $display("FAIL basic_outstanding got=%0d exp=0", outstanding); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b exp=1", empty); end
  endtask

  // Runs after test_basic without reset so the pointers start at 3 and wrap mid-fill.
  task automatic test_full_wrap();
    int acc, pushed, popped;
    logic [ADDR_W-1:0] exp_addr;
    out_ready = 1'b0; cache_done = 1'b0; in_valid = 1'b1; in_cmd = 4'd3; acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_addr = 32'h100 + 32'(i);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (acc != 8) begin bad++; $display("FAIL full_accepted got=%0d exp=8", acc); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    pushed = 0; popped = 0; out_ready = 1'b1;
    for (int c = 0; c < 40 && popped < 16; c++) begin
      in_valid = (pushed < 8);
      in_addr  = 32'h200 + 32'(pushed);
      if (in_valid && in_ready) pushed++;
      cache_done = out_valid;
      if (out_valid) begin
        exp_addr = (popped < 8) ? 32'h100 + 32'(popped) : 32'h200 + 32'(popped - 8);
        total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", popped, out_addr, exp_addr); end
        popped++;
      end
      tick();
    end
    in_valid = 1'b0; cache_done = 1'b0; out_ready = 1'b0;
    total++; if (popped != 16) begin bad++; $display("FAIL wrap_popped got=%0d exp=16", popped); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    total++; if (level !== '0) begin bad++; $display("FAIL wrap_level got=%0d exp=0", level); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL wrap_no_underflow got=%b exp=0", err_underflow); end
  endtask

  task automatic test_barrier();
    logic [CMD_W-1:0]  cmds  [4];
    logic [ADDR_W-1:0] addrs [4];
    logic [ADDR_W-1:0] pa    [4];
    int np;
    do_reset();
    cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd9; cmds[3] = 4'd2;
    addrs[0] = 32'hA0; addrs[1] = 32'hB0; addrs[2] = 32'h0; addrs[3] = 32'hC0;
    pa[0] = '0; pa[1] = '0; pa[2] = '0; pa[3] = '0;
    np = 0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      if (c < 4) begin in_cmd = cmds[c]; in_addr = addrs[c]; end
      if (out_valid && out_ready) begin
        if (np < 4) pa[np] = out_addr;
        np++;
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (np != 2) begin bad++; $display("FAIL bar_pre_issues got=%0d exp=2", np); end
    total++; if (pa[0] !== 32'hA0 || pa[1] !== 32'hB0) begin bad++; $display("FAIL bar_order got=%h,%h exp=a0,b0", pa[0], pa[1]); end
    total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL bar_outstanding got=%0d exp=2", outstanding); end
    total++; if (out_valid !== 1'b0 || out_cmd !== 4'd9) begin bad++; $display("FAIL bar_stall got=v%b c%0d exp=v0 c9", out_valid, out_cmd); end
    cache_done = 1'b1;
    tick();
    total++; if (outstanding !== 3'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL bar_one_left got=o%0d v%b exp=o1 v0", outstanding, out_valid); end
    tick();
    cache_done = 1'b0;
    total++; if (outstanding !== '0 || out_valid !== 1'b1 || out_cmd !== 4'd9) begin bad++; $display("FAIL bar_release got=o%0d v%b c%0d exp=o0 v1 c9", outstanding, out_valid, out_cmd); end
    tick();
    total++; if (out_valid !== 1'b1 || out_cmd !== 4'd2 || out_addr !== 32'hC0) begin bad++; $display("FAIL bar_next got=v%b c%0d a%h exp=v1 c2 ac0", out_valid, out_cmd, out_addr); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL bar_counted got=%0d exp=1", outstanding); end
    tick();
    out_ready = 1'b0;
    total++; if (outstanding !== 3'd2 || empty !== 1'b1) begin bad++; $display("FAIL bar_end got=o%0d e%b exp=o2 e1", outstanding, empty); end
  endtask

  task automatic test_max_out();
    int np;
    do_reset();
    np = 0; out_ready = 1'b1; in_cmd = 4'd0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 5);
      in_addr = 32'h300 + 32'(c);
      if (out_valid && out_ready) np++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (np != 4) begin bad++; $display("FAIL max_issues got=%0d exp=4", np); end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL max_outstanding got=%0d exp=4", outstanding); end
    total++; if (out_valid !== 1'b0 || level !== 4'd1 || out_addr !== 32'h304) begin bad++; $display("FAIL max_stall got=v%b l%0d a%h exp=v0 l1 a304", out_valid, level, out_addr); end
    cache_done = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL max_done_not_comb got=%b exp=0", out_valid); end
    tick();
    cache_done = 1'b0;
    total++; if (outstanding !== 3'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL max_freed got=o%0d v%b exp=o3 v1", outstanding, out_valid); end
    tick();
    out_ready = 1'b0;
    total++; if (outstanding !== 3'd4 || empty !== 1'b1) begin bad++; $display("FAIL max_fifth got=o%0d e%b exp=o4 e1", outstanding, empty); end
  endtask

  task automatic test_errors();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_cmd = 4'd12; in_addr = 32'hDEAD;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL err_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL err_illegal got=%b exp=1", err_illegal); end
    total++; if (empty !== 1'b1 || level !== '0 || out_valid !== 1'b0 || out_cmd !== '0) begin bad++; $display("FAIL err_not_stored got=e%b l%0d v%b c%0d exp=e1 l0 v0 c0", empty, level, out_valid, out_cmd); end
    total++; if (cmd_count !== '0) begin bad++; $display("FAIL err_no_count got=%h exp=0", cmd_count); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL err_unf_pre got=%b exp=0", err_underflow); end
    cache_done = 1'b1;
    tick();
    cache_done = 1'b0;
    total++; if (err_underflow !== 1'b1 || outstanding !== '0) begin bad++; $display("FAIL err_underflow got=u%b o%0d exp=u1 o0", err_underflow, outstanding); end
    tick();
    total++; if ({err_illegal, err_underflow} !== 2'b11) begin bad++; $display("FAIL err_sticky got=%b%b exp=11", err_illegal, err_underflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_cmd = 4'd15; in_addr = 32'h0;
    tick();
    in_cmd = 4'd1;
    for (int i = 0; i < 8; i++) begin
      in_addr = 32'h400 + 32'(i);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    total++; if (level !== 4'd5 || outstanding !== 3'd3 || err_illegal !== 1'b1) begin bad++; $display("FAIL mid_setup got=l%0d o%0d i%b exp=l5 o3 i1", level, outstanding, err_illegal); end
    #2;
    clear_n = 1'b0;
    #1;
    total++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 || level !== '0) begin bad++; $display("FAIL mid_fifo got=e%b f%b r%b l%0d exp=e1 f0 r1 l0", empty, full, in_ready, level); end
    total++; if (out_valid !== 1'b0 || out_cmd !== '0 || out_addr !== '0) begin bad++; $display("FAIL mid_head got=v%b c%0d a%h exp=v0 c0 a0", out_valid, out_cmd, out_addr); end
    total++; if (outstanding !== '0 || cmd_count !== '0) begin bad++; $display("FAIL mid_counts got=o%0d cnt=%h exp=0", outstanding, cmd_count); end
    total++; if ({err_illegal, err_underflow} !== 2'b00) begin bad++; $display("FAIL mid_err got=%b%b exp=00", err_illegal, err_underflow); end
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    tick();
    total++; if (empty !== 1'b1 || outstanding !== '0) begin bad++; $display("FAIL mid_after got=e%b o%0d exp=e1 o0", empty, outstanding); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_barrier();
    test_max_out();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_cmd_queue.md
Name: trace_cmd_queue

Overview:
- Parametrised command/address queue between the trace stimulus source and the cache model (PROJECT).
- Buffers (command, address) pairs and issues them to the cache over a valid/ready handshake.
- Tracks outstanding operations, acknowledged by cache_done. Holds a barrier command (e.g. print-contents) until all earlier operations retire.
- Keeps saturating per-command counters; discards and flags illegal command codes.

Parameters:
- CMD_W, 4, command code width.
- ADDR_W, 32, address width.
- DEPTH, 8, FIFO entries. Power of two, >= 2.
- NUM_CMDS, 10, legal codes are 0..NUM_CMDS-1. Each legal code has one counter.
- BARRIER_CMD, 9, code that waits for outstanding count == 0 before issue.
- MAX_OUT, 4, maximum issued-but-not-done operations. Must be >= 1.
- CNT_W, 32, width of each command counter.

Ports:
- clk  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source presents an entry.
- in_cmd  in  CMD_W  command code.
- in_addr  in  ADDR_W  address.
- in_ready  out  1  queue can accept (= !full).
- out_valid  out  1  head entry eligible for issue.
- out_cmd  out  CMD_W  head command.
- out_addr  out  ADDR_W  head address.
- out_ready  in  1  cache accepts head.
- cache_done  in  1  one-cycle pulse; retires one outstanding operation.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- level  out  clog2(DEPTH)+1  entries stored.
- outstanding  out  clog2(MAX_OUT)+1  issued, not yet done.
- cmd_count  out  NUM_CMDS*CNT_W  counter k occupies bits [k*CNT_W +: CNT_W].
- err_illegal  out  1  sticky: an illegal code was pushed.
- err_underflow  out  1  sticky: cache_done arrived with outstanding == 0.

Behaviour:
- Reset (clear_n low, async):
  - Pointers, level, outstanding and all counters go to 0.
  - empty=1, full=0, in_ready=1, out_valid=0, out_cmd=0, out_addr=0, both err flags 0.
  - Reset mid-operation discards all queued entries and in-flight tracking. There is no partial state.
- Push: in_valid && in_ready at a rising edge.
  - Legal code (in_cmd < NUM_CMDS): store at the write pointer and increment cmd_count[in_cmd]. Counters saturate at all-ones.
  - Illegal code: accepted (in_ready is honoured) but not stored or counted; err_illegal is set.
- FIFO:
  - Show-ahead: out_cmd/out_addr reflect the head entry whenever !empty, and are 0 when empty.
  - Pushed entry is visible at the head the cycle after the push edge. There is no same-cycle bypass.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: level unchanged. Allowed at any level except full, where in_ready=0.
- Issue eligibility (combinational from registered state):
  - out_valid = !empty && (outstanding < MAX_OUT) && (out_cmd != BARRIER_CMD || outstanding == 0).
  - cache_done does not feed out_valid combinationally; a freed slot becomes usable the next cycle.
- Pop/issue: out_valid && out_ready at an edge. Head advances and outstanding increments.
- Retire: cache_done at an edge decrements outstanding.
  - Issue and done in the same cycle: outstanding unchanged.
  - Done with outstanding == 0 and no issue that cycle: counter stays 0 and err_underflow is set.
- Barrier:
  - BARRIER_CMD at the head stalls with out_valid=0 until outstanding reaches 0. Entries behind it are not reordered.
  - The barrier itself counts as outstanding once issued, so the following command waits only on MAX_OUT.
- Err flags are cleared only by reset.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready (in_ready depends on registered level only).
- Counter width is as configured; bits above CNT_W do not exist.

Test Plan:
- Basic flow: reset, push (0,0x10),(1,0x20),(2,0x30) with out_ready=1 and cache_done one cycle after each issue. Required: issued in order, out_valid first high the cycle after the first push, cmd_count[0..2]=1, outstanding returns to 0.
- Full/wrap (DEPTH=8): out_ready=0, push 10 entries with in_valid held. Required: in_ready drops after 8, full=1, level=8. Then drain 8 and push 8 more. Required: addresses are correct across the pointer wrap, empty=1 at the end.
- Barrier: push (0,A),(1,B),(9,0),(2,C), out_ready=1, cache_done withheld. Required: A and B issue, outstanding=2, out_valid=0 with out_cmd=9. Two done pulses bring outstanding to 0, then 9 issues on the next cycle, then C.
- MAX_OUT=4: five reads queued, no done. Required: exactly 4 issue and out_valid stays 0. One done pulse, then the 5th issues the following cycle.
- Errors: push code 12 → not at head, err_illegal=1, no counter changes. Pulse cache_done with outstanding=0 → err_underflow=1, outstanding stays 0.
- Reset mid-run: assert clear_n low while level=5 and outstanding=3. Required: all outputs return to reset values immediately, without waiting for a clock edge.
